aes_128_dec_iter: RTL

- Iterative AES-128 inverse cipher; the receive-side counterpart of the existing aes_128 encryptor.
- Takes a 128-bit ciphertext and cipher key, expands round keys on-chip, runs 10 inverse rounds at one round per clock, and returns plaintext with a start/done handshake.
- Sits beside the encryptor in top-level test harnesses for round-trip checking of golden (Trojan-free) AES output.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_128_dec_iter_if.sv | 13 +
 rtl/aes_inv_round.sv | 39 +++
 rtl/aes_128_dec_iter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative AES-128 cores.
// Holds the S-box tables, the round constants and the FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {StIdle, StExpand, StInit, StRound, StDone} state_e;

  // Rcon[i] feeds the key-expansion step that produces rk[i].
  localparam logic [10:1][7:0] Rcon = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bits [8*(255-b)+7 -: 8], i.e. {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTbl[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTbl[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_128_dec_iter_if.sv
// Request/response bundle of the iterative AES-128 decryptor.
// master drives the request side; slave is the decryptor.
interface aes_128_dec_iter_if;
  logic         start;
  logic [127:0] ct;
  logic [127:0] key;
  logic         ready;
  logic         done;
  logic [127:0] pt;

  modport master (output start, ct, key, input ready, done, pt);
  modport slave  (input start, ct, key, output ready, done, pt);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and, unless last_round is set, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] result
);

  logic [7:0] ark [16];

  function automatic logic [7:0] imc(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return gmul(a, 8'h0e) ^ gmul(b, 8'h0b) ^ gmul(c, 8'h0d) ^ gmul(d, 8'h09);
  endfunction

  always_comb begin
    result = '0;
    // Byte 4*c+r is row r, column c; row r rotates right by r on the inverse path.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[4*c+r] = inv_sbox(data[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (last_round) begin
        for (int r = 0; r < 4; r++) result[127-8*(4*c+r) -: 8] = ark[4*c+r];
      end else begin
        result[127-8*(4*c)   -: 8] = imc(ark[4*c],   ark[4*c+1], ark[4*c+2], ark[4*c+3]);
        result[127-8*(4*c+1) -: 8] = imc(ark[4*c+1], ark[4*c+2], ark[4*c+3], ark[4*c]);
        result[127-8*(4*c+2) -: 8] = imc(ark[4*c+2], ark[4*c+3], ark[4*c],   ark[4*c+1]);
        result[127-8*(4*c+3) -: 8] = imc(ark[4*c+3], ark[4*c],   ark[4*c+1], ark[4*c+2]);
      end
    end
  end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher: on-chip key expansion, one round per clock.
// AES_DEC_KEY_CACHE_EN keeps the last expanded key so a repeated key skips expansion.
module aes_128_dec_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input logic               clk,
  input logic               rst,
  aes_128_dec_iter_if.slave bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_128_dec_iter: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LastIdx = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] rk_q [NR+1];
  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk_wdata;
  logic [127:0] round_out;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic         cache_vld_q;
  logic         cache_we;
`endif

  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
         ^ {rc, 24'h0};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  aes_inv_round u_inv_round (
    .data      (data_q),
    .rk        (rk_q[cnt_q]),
    .last_round(cnt_q == 4'd0),
    .result    (round_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    pt_d     = pt_q;
    rk_we    = 1'b0;
    rk_idx   = cnt_q;
    rk_wdata = bus.key;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_we = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          data_d  = bus.ct;
          rk_we   = 1'b1;
          rk_idx  = 4'd0;
          cnt_d   = 4'd1;
          state_d = StExpand;
`ifdef AES_DEC_KEY_CACHE_EN
          // rk file still holds this key's schedule; reuse it untouched.
          if (cache_vld_q && (bus.key == cache_key_q)) begin
            rk_we   = 1'b0;
            state_d = StInit;
          end
`endif
        end
      end
      StExpand: begin
        rk_we    = 1'b1;
        rk_wdata = key_expand(rk_q[cnt_q - 4'd1], Rcon[cnt_q]);
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LastIdx) begin
          state_d = StInit;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_we = 1'b1;
`endif
        end
      end
      StInit: begin
        data_d  = data_q ^ rk_q[NR];
        cnt_d   = LastIdx - 4'd1;
        state_d = StRound;
      end
      StRound: begin
        data_d = round_out;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          pt_d    = round_out;
          cnt_d   = 4'd0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      pt_q    <= '0;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pt_q    <= pt_d;
      if (rk_we) rk_q[rk_idx] <= rk_wdata;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
    end else if (cache_we) begin
      cache_key_q <= rk_q[0];
      cache_vld_q <= 1'b1;
    end
  end
`endif

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.pt    = pt_q;

endmodule
